// File: rtl/rs_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_alu_pkg
// Description : Shared widths, opcode constants and boolean constants for the
//               integer-ALU reservation station.
// Revision    : 1.0 - initial release
// ============================================================================
package rs_alu_pkg;

    // Default datapath widths shared with dispatch, ROB and the ALU
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_OP_W   = 6;
    localparam int DEF_ROB_W  = 4;

    // Boolean constants
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Internal opcode encoding produced by the decoder (the RS never decodes)
    localparam logic [DEF_OP_W-1:0] OP_LUI   = 6'd1;
    localparam logic [DEF_OP_W-1:0] OP_AUIPC = 6'd2;
    localparam logic [DEF_OP_W-1:0] OP_JAL   = 6'd3;
    localparam logic [DEF_OP_W-1:0] OP_JALR  = 6'd4;
    localparam logic [DEF_OP_W-1:0] OP_BEQ   = 6'd5;
    localparam logic [DEF_OP_W-1:0] OP_ADDI  = 6'd19;
    localparam logic [DEF_OP_W-1:0] OP_ADD   = 6'd28;
    localparam logic [DEF_OP_W-1:0] OP_SUB   = 6'd29;
    localparam logic [DEF_OP_W-1:0] OP_XOR   = 6'd32;
    localparam logic [DEF_OP_W-1:0] OP_AND   = 6'd37;

endpackage : rs_alu_pkg
`default_nettype wire

// File: rtl/rs_alu_pick.sv
`default_nettype none
// ============================================================================
// Module      : rs_alu_pick
// Description : Combinational priority encoder. Returns the lowest set index
//               of the request vector and a found flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_alu_pick #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule : rs_alu_pick
`default_nettype wire

// File: rtl/rs_alu.sv
`default_nettype none
// ============================================================================
// Module      : rs_alu
// Description : Reservation station for the integer ALU. Holds dispatched ops
//               until both operands are valid (CDB snoop on ALU and LSB
//               ports) and issues one ready op per cycle to the ALU.
//               Optional macro RS_AGE_PRIO_EN: issue the oldest ready entry
//               instead of the lowest-index one.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int RS_DEPTH = 8,
    parameter int RS_IDX_W = 3,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int OP_W     = DEF_OP_W,
    parameter int ROB_W    = DEF_ROB_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    // dispatch
    input  logic              disp_valid_in,
    input  logic [ADDR_W-1:0] disp_pc_in,
    input  logic [OP_W-1:0]   disp_op_in,
    input  logic [DATA_W-1:0] disp_imm_in,
    input  logic [ROB_W-1:0]  disp_rob_in,
    input  logic              disp_qj_valid_in,
    input  logic              disp_qk_valid_in,
    input  logic [ROB_W-1:0]  disp_qj_in,
    input  logic [ROB_W-1:0]  disp_qk_in,
    input  logic [DATA_W-1:0] disp_vj_in,
    input  logic [DATA_W-1:0] disp_vk_in,
    output logic              full_out,
    // issue to ALU
    input  logic              alu_idle_in,
    output logic              rdy_rs_out,
    output logic [ADDR_W-1:0] pc_rs_out,
    output logic [OP_W-1:0]   opcode_rs_out,
    output logic [DATA_W-1:0] vj_rs_out,
    output logic [DATA_W-1:0] vk_rs_out,
    output logic [DATA_W-1:0] imm_rs_out,
    output logic [ROB_W-1:0]  rob_id_rs_out,
    // CDB snoop
    input  logic              cdb_a_rdy_in,
    input  logic [DATA_W-1:0] cdb_a_result_in,
    input  logic [ROB_W-1:0]  cdb_a_rob_in,
    input  logic              cdb_l_rdy_in,
    input  logic [DATA_W-1:0] cdb_l_result_in,
    input  logic [ROB_W-1:0]  cdb_l_rob_in
);

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    logic [RS_DEPTH-1:0] r_busy;
    logic [RS_DEPTH-1:0] r_qj_v;
    logic [RS_DEPTH-1:0] r_qk_v;
    logic [ADDR_W-1:0]   r_pc  [RS_DEPTH];
    logic [OP_W-1:0]     r_op  [RS_DEPTH];
    logic [DATA_W-1:0]   r_imm [RS_DEPTH];
    logic [ROB_W-1:0]    r_rob [RS_DEPTH];
    logic [ROB_W-1:0]    r_qj  [RS_DEPTH];
    logic [ROB_W-1:0]    r_qk  [RS_DEPTH];
    logic [DATA_W-1:0]   r_vj  [RS_DEPTH];
    logic [DATA_W-1:0]   r_vk  [RS_DEPTH];

    // Registered issue port
    logic              r_rdy_out;
    logic [ADDR_W-1:0] r_pc_out;
    logic [OP_W-1:0]   r_op_out;
    logic [DATA_W-1:0] r_vj_out;
    logic [DATA_W-1:0] r_vk_out;
    logic [DATA_W-1:0] r_imm_out;
    logic [ROB_W-1:0]  r_rob_out;

    // Selection results
    logic [RS_DEPTH-1:0] w_free_vec;
    logic [RS_DEPTH-1:0] w_ready_vec;
    logic [RS_IDX_W-1:0] w_free_idx;
    logic                w_free_found;
    logic [RS_IDX_W-1:0] w_sel_idx;
    logic                w_sel_found;
    logic                w_do_disp;
    logic                w_do_issue;

    // Dispatch operands after same-cycle CDB forwarding
    logic              w_disp_qj_v;
    logic              w_disp_qk_v;
    logic [DATA_W-1:0] w_disp_vj;
    logic [DATA_W-1:0] w_disp_vk;

    assign w_free_vec  = ~r_busy;
    assign w_ready_vec = r_busy & ~r_qj_v & ~r_qk_v;
    assign full_out    = &r_busy;
    assign w_do_disp   = disp_valid_in & ~full_out;
    assign w_do_issue  = alu_idle_in & w_sel_found;

    rs_alu_pick #(
        .N     (RS_DEPTH),
        .IDX_W (RS_IDX_W)
    ) u_free_pick (
        .i_req   (w_free_vec),
        .o_idx   (w_free_idx),
        .o_found (w_free_found)
    );

`ifdef RS_AGE_PRIO_EN
    localparam int AGE_W = RS_IDX_W + 1;

    logic [AGE_W-1:0] r_age_cnt;
    logic [AGE_W-1:0] r_age [RS_DEPTH];
    logic [AGE_W-1:0] w_age_dist;
    logic [AGE_W-1:0] w_best_dist;

    // Oldest ready entry: largest modular distance behind the dispatch counter
    always_comb begin
        w_sel_idx   = '0;
        w_sel_found = FALSE;
        w_best_dist = '0;
        w_age_dist  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_age_dist = r_age_cnt - r_age[i];
            if (w_ready_vec[i] && (!w_sel_found || (w_age_dist > w_best_dist))) begin
                w_sel_idx   = RS_IDX_W'(i);
                w_sel_found = TRUE;
                w_best_dist = w_age_dist;
            end
        end
    end

    // Age stamps are written on dispatch; the counter wraps freely
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_age_cnt <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_age[i] <= '0;
            end
        end else if (rdy_in && !clear_in && w_do_disp) begin
            r_age[w_free_idx] <= r_age_cnt;
            r_age_cnt         <= r_age_cnt + 1'b1;
        end
    end
`else
    rs_alu_pick #(
        .N     (RS_DEPTH),
        .IDX_W (RS_IDX_W)
    ) u_ready_pick (
        .i_req   (w_ready_vec),
        .o_idx   (w_sel_idx),
        .o_found (w_sel_found)
    );
`endif

    // Forward a CDB result broadcast in the dispatch cycle; LSB port wins ties
    always_comb begin
        w_disp_qj_v = disp_qj_valid_in;
        w_disp_vj   = disp_vj_in;
        w_disp_qk_v = disp_qk_valid_in;
        w_disp_vk   = disp_vk_in;
        if (disp_qj_valid_in) begin
            if (cdb_l_rdy_in && (cdb_l_rob_in == disp_qj_in)) begin
                w_disp_qj_v = FALSE;
                w_disp_vj   = cdb_l_result_in;
            end else if (cdb_a_rdy_in && (cdb_a_rob_in == disp_qj_in)) begin
                w_disp_qj_v = FALSE;
                w_disp_vj   = cdb_a_result_in;
            end
        end
        if (disp_qk_valid_in) begin
            if (cdb_l_rdy_in && (cdb_l_rob_in == disp_qk_in)) begin
                w_disp_qk_v = FALSE;
                w_disp_vk   = cdb_l_result_in;
            end else if (cdb_a_rdy_in && (cdb_a_rob_in == disp_qk_in)) begin
                w_disp_qk_v = FALSE;
                w_disp_vk   = cdb_a_result_in;
            end
        end
    end

    // Entry state: flush, CDB snoop, issue/free and dispatch write
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy    <= '0;
            r_qj_v    <= '0;
            r_qk_v    <= '0;
            r_rdy_out <= 1'b0;
            r_pc_out  <= '0;
            r_op_out  <= '0;
            r_vj_out  <= '0;
            r_vk_out  <= '0;
            r_imm_out <= '0;
            r_rob_out <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_pc[i]  <= '0;
                r_op[i]  <= '0;
                r_imm[i] <= '0;
                r_rob[i] <= '0;
                r_qj[i]  <= '0;
                r_qk[i]  <= '0;
                r_vj[i]  <= '0;
                r_vk[i]  <= '0;
            end
        end else if (clear_in) begin
            // Mispredict flush; any concurrent dispatch is dropped
            r_busy    <= '0;
            r_qj_v    <= '0;
            r_qk_v    <= '0;
            r_rdy_out <= 1'b0;
        end else if (!rdy_in) begin
            // Frozen, but never present the same op twice
            r_rdy_out <= 1'b0;
        end else begin
            // Wakeup of pending operands; j and k are independent
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (r_busy[i] && r_qj_v[i]) begin
                    if (cdb_l_rdy_in && (cdb_l_rob_in == r_qj[i])) begin
                        r_vj[i]   <= cdb_l_result_in;
                        r_qj_v[i] <= FALSE;
                    end else if (cdb_a_rdy_in && (cdb_a_rob_in == r_qj[i])) begin
                        r_vj[i]   <= cdb_a_result_in;
                        r_qj_v[i] <= FALSE;
                    end
                end
                if (r_busy[i] && r_qk_v[i]) begin
                    if (cdb_l_rdy_in && (cdb_l_rob_in == r_qk[i])) begin
                        r_vk[i]   <= cdb_l_result_in;
                        r_qk_v[i] <= FALSE;
                    end else if (cdb_a_rdy_in && (cdb_a_rob_in == r_qk[i])) begin
                        r_vk[i]   <= cdb_a_result_in;
                        r_qk_v[i] <= FALSE;
                    end
                end
            end

            // Issue uses pre-edge readiness; the slot frees at this edge
            if (w_do_issue) begin
                r_rdy_out         <= 1'b1;
                r_pc_out          <= r_pc[w_sel_idx];
                r_op_out          <= r_op[w_sel_idx];
                r_vj_out          <= r_vj[w_sel_idx];
                r_vk_out          <= r_vk[w_sel_idx];
                r_imm_out         <= r_imm[w_sel_idx];
                r_rob_out         <= r_rob[w_sel_idx];
                r_busy[w_sel_idx] <= 1'b0;
            end else begin
                r_rdy_out <= 1'b0;
            end

            // Free slot comes from pre-edge busy, so a slot freed by issue
            // this edge is never reused in the same cycle
            if (w_do_disp && w_free_found) begin
                r_busy[w_free_idx] <= 1'b1;
                r_pc[w_free_idx]   <= disp_pc_in;
                r_op[w_free_idx]   <= disp_op_in;
                r_imm[w_free_idx]  <= disp_imm_in;
                r_rob[w_free_idx]  <= disp_rob_in;
                r_qj[w_free_idx]   <= disp_qj_in;
                r_qk[w_free_idx]   <= disp_qk_in;
                r_qj_v[w_free_idx] <= w_disp_qj_v;
                r_qk_v[w_free_idx] <= w_disp_qk_v;
                r_vj[w_free_idx]   <= w_disp_vj;
                r_vk[w_free_idx]   <= w_disp_vk;
            end
        end
    end

    assign rdy_rs_out    = r_rdy_out;
    assign pc_rs_out     = r_pc_out;
    assign opcode_rs_out = r_op_out;
    assign vj_rs_out     = r_vj_out;
    assign vk_rs_out     = r_vk_out;
    assign imm_rs_out    = r_imm_out;
    assign rob_id_rs_out = r_rob_out;

endmodule : rs_alu
`default_nettype wire

// File: doc/rs_alu.md
Name: rs_alu

Overview:
- Reservation station feeding the integer ALU.
- Accepts decoded ops from dispatch and holds them until both source operands are valid.
- Snoops the two CDB ports (ALU and LSB) for operand wakeup.
- Issues at most one ready op per cycle on the RS→ALU interface (rdy/pc/opcode/vj/vk/imm/rob_id, back-pressured by the ALU's idle flag).

Parameters:
- RS_DEPTH, 8, number of entries (power of two, 2..16)
- RS_IDX_W, 3, log2(RS_DEPTH)
- ADDR_W, 32, pc width
- DATA_W, 32, operand/result width
- OP_W, 6, internal opcode width
- ROB_W, 4, ROB tag width

Ports:
- clk_in  in  1  clock, rising edge
- rst_in  in  1  reset, asynchronous, active-high
- rdy_in  in  1  global enable; state frozen when low
- clear_in  in  1  sync flush from ROB (mispredict)
- disp_valid_in  in  1  dispatch request
- disp_pc_in  in  ADDR_W  instruction pc
- disp_op_in  in  OP_W  opcode
- disp_imm_in  in  DATA_W  immediate
- disp_rob_in  in  ROB_W  destination ROB tag
- disp_qj_valid_in / disp_qk_valid_in  in  1  operand j/k still pending
- disp_qj_in / disp_qk_in  in  ROB_W  producing ROB tag
- disp_vj_in / disp_vk_in  in  DATA_W  value if not pending
- full_out  out  1  no free entry
- alu_idle_in  in  1  ALU can accept
- rdy_rs_out  out  1  issue valid to ALU
- pc_rs_out  out  ADDR_W
- opcode_rs_out  out  OP_W
- vj_rs_out / vk_rs_out / imm_rs_out  out  DATA_W
- rob_id_rs_out  out  ROB_W
- cdb_a_rdy_in, cdb_a_result_in [DATA_W], cdb_a_rob_in [ROB_W]  in  ALU broadcast
- cdb_l_rdy_in, cdb_l_result_in [DATA_W], cdb_l_rob_in [ROB_W]  in  LSB broadcast

Behaviour:
- Reset (async, rst_in=1):
  - All entries invalid.
  - rdy_rs_out=0; all payload outputs 0.
  - full_out=0 (derived).
- Entry fields: busy, pc, op, imm, rob, qj_v, qj, vj, qk_v, qk, vk.
- rdy_in=0: no state change on the edge; rdy_rs_out cleared to 0 so the same op is never presented twice.
- full_out: combinational, 1 iff all RS_DEPTH entries busy. An issue in the same cycle does not lower it.
- Dispatch when disp_valid_in && !full_out:
  - Written at the edge into the lowest-index free entry.
  - Dispatch while full is ignored; the bench flags it as a protocol error.
- Same-cycle wakeup on dispatch: if a disp_q*_valid_in tag equals an active CDB rob tag that cycle, the entry stores the CDB value with q*_v=0.
  - If both CDB ports match, the LSB port wins; the ROB guarantees this cannot occur.
- CDB snoop: each edge, every busy entry with q*_v=1 and a matching tag on an active CDB port captures the result and clears q*_v. j and k wake independently.
- Ready entry: busy && !qj_v && !qk_v, evaluated on pre-edge state. A value woken this edge is issuable next cycle.
- Issue:
  - When alu_idle_in=1 and a ready entry exists, the selected entry's payload is registered onto the *_rs_out ports, rdy_rs_out=1 for exactly one cycle, and the entry is freed at the same edge.
  - Otherwise rdy_rs_out=0 and payload holds its last value.
- Latency:
  - Dispatch with operands valid → rdy_rs_out at the 2nd edge after dispatch: 1 cycle in RS minimum.
  - CDB wakeup → issue next edge.
- Selection: lowest-index ready entry.
- Simultaneous dispatch and issue: allowed. A freed entry is not reusable until the following cycle.
- clear_in=1 at an edge:
  - All entries invalidated; rdy_rs_out=0.
  - Concurrent dispatch dropped.
  - Priority: rst_in > clear_in > rdy_in.
- Unused-operand ops (LUI, AUIPC, JAL, I-type k) are dispatched with q*_valid_in=0; the RS does not decode opcodes.

Optional Feature:
- RS_AGE_PRIO_EN defined:
  - Each entry carries an RS_IDX_W+1-bit age stamp from a wrapping dispatch counter.
  - Issue selects the oldest ready entry, using modular comparison relative to the oldest busy stamp.
- Undefined: lowest-index ready entry. No age storage.

Decomposition:
- Shared define.vh holds ADDR/DATA/OP/ROB widths, opcode constants, and TRUE/FALSE. No new opcodes added.
- Sub-module rs_pick: combinational priority encoder (ready vector → index + found). Instantiated twice: free-slot select and ready select, the latter replaced by age logic under RS_AGE_PRIO_EN.

Test Plan:
- Reset mid-stream:
  - Stimulus: fill 3 entries, assert rst_in asynchronously between edges.
  - Response: rdy_rs_out=0 and full_out=0 immediately; no issue afterwards.
- Ready dispatch:
  - Stimulus: ADD, vj=5, vk=7, rob=3, alu_idle_in=1.
  - Response: next cycle rdy_rs_out=1, vj=5, vk=7, rob_id=3, one cycle only.
- Pending operand:
  - Stimulus: qj=2 pending; cdb_a broadcasts rob 2 result 0x10 two cycles later.
  - Response: issue on the edge after the broadcast with vj_rs_out=0x10.
- Same-cycle wakeup:
  - Stimulus: dispatch qk=6 pending while cdb_l_rob_in=6, result 0xAB.
  - Response: issues next cycle with vk=0xAB, no hang.
- Full and flush:
  - Stimulus: 8 dispatches with pending tags.
  - Response: full_out=1; a 9th dispatch is ignored. clear_in → full_out=0, no rdy_rs_out; later CDB tag 5 causes no issue.
- Ordering:
  - Stimulus: entries 0 and 5 ready in the same cycle, entry 5 dispatched first.
  - Response: entry 0 issues first; entry 5 first with RS_AGE_PRIO_EN. rdy_in=0 freezes both.
